// File: rtl/qla_agent_controller_if.sv
// Interface bundling the run-control and QLA-facing signals of the agent
// controller. The controller is the master; the QLA/run-control side is
// the slave.
interface qla_agent_controller_if;
  logic               start;
  logic signed [31:0] Qnext_0;
  logic signed [31:0] Qnext_1;
  logic signed [31:0] Qnext_2;
  logic signed [31:0] Qnext_3;
  logic [4:0]         current_state;
  logic [4:0]         next_state;
  logic [1:0]         act;
  logic [3:0]         step;
  logic               decoder_en;
  logic               busy;
  logic               episode_done;
  logic               goal_reached;
  logic [15:0]        episode_count;

  modport master (
    input  start, Qnext_0, Qnext_1, Qnext_2, Qnext_3,
    output current_state, next_state, act, step, decoder_en,
           busy, episode_done, goal_reached, episode_count
  );

  modport slave (
    output start, Qnext_0, Qnext_1, Qnext_2, Qnext_3,
    input  current_state, next_state, act, step, decoder_en,
           busy, episode_done, goal_reached, episode_count
  );
endinterface

// File: rtl/qla_agent_controller.sv
// Episode sequencer and epsilon-greedy action selector for the QLA core.
// Walks a 5x5 grid (states 1..25, row-major), looks up Q-values for the
// current state, picks an action, computes the grid move and holds each
// transition stable on the QLA inputs while decoder_en is high.
module qla_agent_controller #(
  parameter int unsigned READ_LAT    = 2,
  parameter int unsigned HOLD_CYCLES = 5,
  parameter logic [7:0]  EPSILON     = 8'd26,
  parameter logic [4:0]  START_STATE = 5'd1,
  parameter logic [4:0]  GOAL_STATE  = 5'd25,
  parameter logic [3:0]  MAX_STEP    = 4'd15,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input logic                    clk,
  input logic                    rst,
  qla_agent_controller_if.master bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOOKUP  = 3'd1;
  localparam logic [2:0] ST_SELECT  = 3'd2;
  localparam logic [2:0] ST_UPDATE  = 3'd3;
  localparam logic [2:0] ST_ADVANCE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // Last value of the shared wait counter in LOOKUP and UPDATE
  localparam logic [7:0] READ_LAST = 8'(READ_LAT - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic [2:0]         state_reg;
  logic [4:0]         cur_reg;
  logic [4:0]         ns_reg;
  logic [4:0]         current_state_reg;
  logic [4:0]         next_state_reg;
  logic [1:0]         act_reg;
  logic [3:0]         step_reg;
  logic               decoder_en_reg;
  logic               busy_reg;
  logic               episode_done_reg;
  logic               goal_reached_reg;
  logic [15:0]        episode_count_reg;
  logic [7:0]         lfsr_reg;
  logic [7:0]         wait_reg;
  logic signed [31:0] q_reg [4];
  logic signed [31:0] q_in  [4];

  logic [8:0]         eps_diff;
  logic               explore;
  logic signed [31:0] best_q;
  logic [1:0]         greedy_act;
  logic [1:0]         sel_act;
  logic [4:0]         sel_ns;
  logic               at_left;
  logic               at_right;

  assign q_in[0] = bus.Qnext_0;
  assign q_in[1] = bus.Qnext_1;
  assign q_in[2] = bus.Qnext_2;
  assign q_in[3] = bus.Qnext_3;

  // Free-running 8-bit Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end
  end

  // Greedy choice: strict signed greater-than keeps the lowest index on ties
  always_comb begin
    best_q     = q_reg[0];
    greedy_act = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (q_reg[i] > best_q) begin
        best_q     = q_reg[i];
        greedy_act = 2'(i);
      end
    end
  end

  // Explore when lfsr < EPSILON; the borrow of a 9-bit subtract gives the compare
  always_comb begin
    eps_diff = {1'b0, lfsr_reg} - {1'b0, EPSILON};
    explore  = eps_diff[8];
    sel_act  = explore ? lfsr_reg[1:0] : greedy_act;
  end

  // Grid move; a move that would leave the grid bumps the wall and stays put
  always_comb begin
    at_left  = cur_reg inside {5'd1, 5'd6, 5'd11, 5'd16, 5'd21};
    at_right = cur_reg inside {5'd5, 5'd10, 5'd15, 5'd20, 5'd25};
    sel_ns   = cur_reg;
    case (sel_act)
      2'b00:   if (cur_reg <= 5'd20) sel_ns = cur_reg + 5'd5;
      2'b01:   if (cur_reg >= 5'd6)  sel_ns = cur_reg - 5'd5;
      2'b10:   if (!at_left)         sel_ns = cur_reg - 5'd1;
      default: if (!at_right)        sel_ns = cur_reg + 5'd1;
    endcase
  end

  // Episode FSM; every output is a register updated only on state changes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      cur_reg           <= START_STATE;
      ns_reg            <= START_STATE;
      current_state_reg <= START_STATE;
      next_state_reg    <= START_STATE;
      act_reg           <= 2'd0;
      step_reg          <= 4'd0;
      decoder_en_reg    <= 1'b0;
      busy_reg          <= 1'b0;
      episode_done_reg  <= 1'b0;
      goal_reached_reg  <= 1'b0;
      episode_count_reg <= 16'd0;
      wait_reg          <= 8'd0;
      for (int i = 0; i < 4; i++) q_reg[i] <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            state_reg        <= ST_LOOKUP;
            busy_reg         <= 1'b1;
            cur_reg          <= START_STATE;
            next_state_reg   <= START_STATE;
            step_reg         <= 4'd0;
            goal_reached_reg <= 1'b0;
            wait_reg         <= 8'd0;
          end
        end
        ST_LOOKUP: begin
          if (wait_reg == READ_LAST) begin
            for (int i = 0; i < 4; i++) q_reg[i] <= q_in[i];
            state_reg <= ST_SELECT;
          end else begin
            wait_reg <= wait_reg + 8'd1;
          end
        end
        ST_SELECT: begin
          act_reg           <= sel_act;
          ns_reg            <= sel_ns;
          step_reg          <= step_reg + 4'd1;
          current_state_reg <= cur_reg;
          next_state_reg    <= sel_ns;
          decoder_en_reg    <= 1'b1;
          wait_reg          <= 8'd0;
          state_reg         <= ST_UPDATE;
        end
        ST_UPDATE: begin
          if (wait_reg == HOLD_LAST) begin
            decoder_en_reg <= 1'b0;
            state_reg      <= ST_ADVANCE;
          end else begin
            wait_reg <= wait_reg + 8'd1;
          end
        end
        ST_ADVANCE: begin
          if (ns_reg == GOAL_STATE || step_reg == MAX_STEP) begin
            episode_done_reg  <= 1'b1;
            episode_count_reg <= episode_count_reg + 16'd1;
            goal_reached_reg  <= (ns_reg == GOAL_STATE);
            state_reg         <= ST_DONE;
          end else begin
            cur_reg        <= ns_reg;
            next_state_reg <= ns_reg;
            wait_reg       <= 8'd0;
            state_reg      <= ST_LOOKUP;
          end
        end
        ST_DONE: begin
          episode_done_reg <= 1'b0;
          if (bus.start) begin
            // Back-to-back episode: skip IDLE and restart directly
            cur_reg          <= START_STATE;
            next_state_reg   <= START_STATE;
            step_reg         <= 4'd0;
            goal_reached_reg <= 1'b0;
            wait_reg         <= 8'd0;
            state_reg        <= ST_LOOKUP;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          decoder_en_reg   <= 1'b0;
          episode_done_reg <= 1'b0;
          busy_reg         <= 1'b0;
          state_reg        <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.current_state = current_state_reg;
  assign bus.next_state    = next_state_reg;
  assign bus.act           = act_reg;
  assign bus.step          = step_reg;
  assign bus.decoder_en    = decoder_en_reg;
  assign bus.busy          = busy_reg;
  assign bus.episode_done  = episode_done_reg;
  assign bus.goal_reached  = goal_reached_reg;
  assign bus.episode_count = episode_count_reg;

endmodule

// File: doc/qla_agent_controller.md
Name: qla_agent_controller

Overview:
Episode sequencer and action selector that drives the QLA core's environment-side inputs: current_state, next_state, act, step and decoder_en.
It walks a 5x5 grid (states 1..25, row-major, state = 5*row + col + 1) and reads the Q-values that QLA returns on Qnext_0..Qnext_3.
It picks actions epsilon-greedily, computes the grid transition, and holds each transition stable for QLA to perform its update.
It sits between the top-level run control and the QLA instance, replacing the hand-driven stimulus used so far.

Parameters:
READ_LAT, 2, cycles from presenting a state on next_state to valid Qnext_0..3 from QLA
HOLD_CYCLES, 5, cycles each transition is held with decoder_en=1
EPSILON, 8'd26, explore when lfsr < EPSILON (about 10%); 0 = pure greedy
START_STATE, 5'd1, episode start state
GOAL_STATE, 5'd25, terminal state
MAX_STEP, 4'd15, last allowed step number in an episode
LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  level; while high, episodes run back-to-back
Qnext_0..Qnext_3  in  32 each  signed Q(s,a) for a = 0..3 of the state on next_state
current_state  out  5  state the agent acts from
next_state  out  5  resulting state / lookup address
act  out  2  chosen action
step  out  4  transition index within the episode, 1..MAX_STEP
decoder_en  out  1  QLA update enable
busy  out  1  high outside IDLE
episode_done  out  1  one-cycle pulse at episode end
goal_reached  out  1  registered; set at episode end if the goal was hit, cleared at the next episode start
episode_count  out  16  completed episodes; wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async, any state, including mid-UPDATE): FSM -> IDLE. All outputs settle to these values:
  - current_state = next_state = START_STATE
  - act = 0, step = 0
  - decoder_en, busy, episode_done, goal_reached = 0
  - episode_count = 0
  - lfsr = LFSR_SEED
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts every cycle out of reset.
- Action encoding:
  - 00: +5 (down)
  - 01: -5 (up)
  - 10: -1 (left)
  - 11: +1 (right)
  - A move leaving the grid (row < 0, row > 4, or column wrap) leaves the state unchanged (wall bump).
- FSM:
  - IDLE: if start=1 -> LOOKUP. On entry: cur = START_STATE, step counter = 0, goal_reached cleared.
  - LOOKUP: next_state = cur, decoder_en = 0. Wait READ_LAT cycles, then register Qnext_0..3 -> SELECT.
  - SELECT (1 cycle):
    - If the LFSR value this cycle < EPSILON: act = lfsr[1:0].
    - Else act = index of the maximum signed Q; ties resolve to the lowest index.
    - Compute ns from the move rules, step = step + 1 -> UPDATE.
  - UPDATE: current_state = cur, next_state = ns, act and step held constant. decoder_en = 1 for exactly HOLD_CYCLES cycles -> ADVANCE.
  - ADVANCE (1 cycle): decoder_en = 0.
    - If ns == GOAL_STATE or step == MAX_STEP -> DONE.
    - Else cur = ns -> LOOKUP.
  - DONE (1 cycle):
    - episode_done = 1, episode_count + 1.
    - goal_reached = (ns == GOAL_STATE). The goal takes priority if both conditions hit on the same step.
    - If start = 1 -> IDLE re-entry is skipped: cur = START_STATE, step = 0 -> LOOKUP. Else -> IDLE.
- Timing: outputs are registered and change only on state-transition edges. Each transition costs READ_LAT + 1 + HOLD_CYCLES + 1 cycles; DONE adds 1.
- start deasserted mid-episode: the episode completes; the block stops at DONE.
- Greedy comparison is a full 32-bit signed compare (-25 < 0).

Test Plan:
1. Reset then idle: rst = 1 for 5 cycles, start = 0 -> current_state = 1, step = 0, decoder_en = 0, busy = 0, episode_count = 0; hold 20 cycles, no change.
2. Greedy argmax: EPSILON = 0, state 1, Qnext = {0: -50, 1: -25, 2: 100, 3: 100} -> act = 2'b10. Left from column 0 is a wall: next_state = 1, step = 1, decoder_en high exactly 5 cycles.
3. Greedy down move: EPSILON = 0, state 1, Qnext = {0: 100, others 0} -> act = 00, next_state = 6. The next LOOKUP presents next_state = 6.
4. Goal termination: EPSILON = 0, Q forces down/right from state 1. The path reaches 25 -> episode_done pulses once, goal_reached = 1, episode_count = 1, step ≤ 8. With start still high, the next LOOKUP uses state 1 and step restarts at 1.
5. Max-step termination: all Q = 0, so act = 00 and the agent walls at 21. After step 15 -> episode_done = 1, goal_reached = 0.
6. Reset mid-UPDATE: assert rst asynchronously on the 3rd decoder_en cycle -> decoder_en, busy and step drop to 0 immediately. After release with start = 1 the episode restarts from state 1.
